// File: rtl/neopix_pkg.sv
// Shared types for the NeoPixel frame scheduler: pixel/colour types,
// scheduler FSM states and the default strip length.
// With NEOPIX_CLEAR_EN defined the state enum gains the CLEAR state.
package neopix_pkg;

  localparam int NUM_PIXELS_DEF = 16;
  localparam int PIX_W          = 5;
  localparam int COLOR_W        = 3;

  // {red, blue, green}
  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [PIX_W-1:0]   pixel_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_HOLD,
    S_WAIT
`ifdef NEOPIX_CLEAR_EN
    ,
    S_CLEAR
`endif
  } state_t;

  // True when idx addresses a pixel that exists on a strip of n pixels.
  function automatic logic pixel_in_range(input pixel_idx_t idx, input int n);
    return (int'({1'b0, idx}) < n);
  endfunction

endpackage

// File: rtl/neopix_frame_sched_rr_arb.sv
// Two-way round-robin arbiter. r_ptr names the requester favoured when
// both request; it flips to the other requester on every accepted grant.
module neopix_rr_arb (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // One-hot grant from the current requests and the tie-break pointer.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  // After granting requester 0 favour 1, and vice versa.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr <= 1'b0;
    end else if (i_advance && (|o_gnt)) begin
      r_ptr <= o_gnt[0];
    end
  end

endmodule

// File: rtl/neopix_frame_sched.sv
// Frame scheduler and two-way arbiter in front of the NeoPixel strip
// driver. Serialises single-pixel writes onto the driver load port,
// issues a frame-rate go strobe when the buffer is dirty, and holds off
// traffic while the driver shifts a frame out.
// Optional feature: NEOPIX_CLEAR_EN adds i_clear_all and the CLEAR state.
//
// state | meaning
// IDLE  | pick: pending go, stale tick drop, clear, or arbitrate a request
// LOAD  | grant cycle; registered write goes to the driver next cycle
// SEND  | drv_go cycle; clears go_pending and dirty
// HOLD  | one cycle ignoring drv_ready while the driver drops it
// WAIT  | wait for the driver to return ready, then frame_done
// CLEAR | (optional) colour-0 load to every pixel, one per 2 cycles
module neopix_frame_sched
  import neopix_pkg::*;
#(
  parameter int NUM_PIXELS   = NUM_PIXELS_DEF,
  parameter int FRAME_CYCLES = 833_333
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [1:0]             i_req,
  input  pixel_idx_t [1:0]       i_req_pixel,
  input  color_t     [1:0]       i_req_color,
  output logic [1:0]             o_gnt,
  input  logic                   i_drv_ready,
  output logic                   o_drv_load,
  output pixel_idx_t             o_drv_pixel,
  output color_t                 o_drv_color,
  output logic                   o_drv_go,
  output logic                   o_frame_done
`ifdef NEOPIX_CLEAR_EN
  ,
  input  logic                   i_clear_all
`endif
);

  localparam int TMR_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FRAME_CYCLES - 1);

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_go_pending;
  logic             r_dirty;
  pixel_idx_t       r_pix;
  color_t           r_col;
  logic [1:0]       r_gnt;
  logic             r_drv_load;
  pixel_idx_t       r_drv_pixel;
  color_t           r_drv_color;
  logic             r_drv_go;
  logic             r_frame_done;

  state_t           w_state_nxt;
  logic             w_wrap;
  logic [1:0]       w_arb_gnt;
  logic             w_win;
  logic             w_adv;
  logic             w_capture;
  logic [1:0]       w_gnt_nxt;
  logic             w_load_nxt;
  pixel_idx_t       w_load_pix;
  color_t           w_load_col;
  logic             w_go_nxt;
  logic             w_done_nxt;
  logic             w_go_clr;
  logic             w_dirty_set;
  logic             w_dirty_clr;

`ifdef NEOPIX_CLEAR_EN
  logic             r_clear_pending;
  pixel_idx_t       r_clr_idx;
  logic             r_clr_phase;
  logic             w_clr_take;
  pixel_idx_t       w_clr_idx_nxt;
  logic             w_clr_phase_nxt;
`endif

  assign w_wrap = (r_timer == TMR_LAST);
  assign w_win  = w_arb_gnt[1];

  neopix_rr_arb u_arb (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .i_advance (w_adv),
    .o_gnt     (w_arb_gnt)
  );

  // Next-state and strobe decode; every strobe is registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_capture   = 1'b0;
    w_gnt_nxt   = 2'b00;
    w_load_nxt  = 1'b0;
    w_load_pix  = '0;
    w_load_col  = '0;
    w_go_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_go_clr    = 1'b0;
    w_dirty_set = 1'b0;
    w_dirty_clr = 1'b0;
`ifdef NEOPIX_CLEAR_EN
    w_clr_take      = 1'b0;
    w_clr_idx_nxt   = r_clr_idx;
    w_clr_phase_nxt = r_clr_phase;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_go_pending && r_dirty && i_drv_ready) begin
          w_go_nxt    = 1'b1;
          w_state_nxt = S_SEND;
        end else if (r_go_pending && !r_dirty) begin
          // Nothing changed since the last frame: drop the tick silently.
          w_go_clr = 1'b1;
        end
`ifdef NEOPIX_CLEAR_EN
        else if (r_clear_pending) begin
          w_clr_take      = 1'b1;
          w_clr_idx_nxt   = '0;
          w_clr_phase_nxt = 1'b0;
          w_state_nxt     = S_CLEAR;
        end
`endif
        else if ((|i_req) && i_drv_ready) begin
          w_adv       = 1'b1;
          w_capture   = 1'b1;
          w_gnt_nxt   = w_arb_gnt;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // Out-of-range writes are granted but never reach the driver.
        if (pixel_in_range(r_pix, NUM_PIXELS)) begin
          w_load_nxt  = 1'b1;
          w_load_pix  = r_pix;
          w_load_col  = r_col;
          w_dirty_set = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end
      S_SEND: begin
        w_go_clr    = 1'b1;
        w_dirty_clr = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_drv_ready) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef NEOPIX_CLEAR_EN
      S_CLEAR: begin
        if (!r_clr_phase) begin
          // Issue phase waits for the driver; the index is kept meanwhile.
          if (i_drv_ready) begin
            w_load_nxt      = 1'b1;
            w_load_pix      = r_clr_idx;
            w_load_col      = '0;
            w_clr_phase_nxt = 1'b1;
          end
        end else begin
          w_clr_phase_nxt = 1'b0;
          if (r_clr_idx == PIX_W'(NUM_PIXELS - 1)) begin
            w_clr_idx_nxt = '0;
            w_dirty_set   = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_clr_idx_nxt = r_clr_idx + PIX_W'(1);
          end
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, frame timer, flags, captured write and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_go_pending <= 1'b0;
      r_dirty      <= 1'b0;
      r_pix        <= '0;
      r_col        <= '0;
      r_gnt        <= 2'b00;
      r_drv_load   <= 1'b0;
      r_drv_pixel  <= '0;
      r_drv_color  <= '0;
      r_drv_go     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_wrap ? '0 : r_timer + TMR_W'(1);
      // A tick always wins over a same-cycle clear so it is never lost.
      if (w_wrap) begin
        r_go_pending <= 1'b1;
      end else if (w_go_clr) begin
        r_go_pending <= 1'b0;
      end
      if (w_dirty_set) begin
        r_dirty <= 1'b1;
      end else if (w_dirty_clr) begin
        r_dirty <= 1'b0;
      end
      if (w_capture) begin
        r_pix <= i_req_pixel[w_win];
        r_col <= i_req_color[w_win];
      end
      r_gnt        <= w_gnt_nxt;
      r_drv_load   <= w_load_nxt;
      r_drv_pixel  <= w_load_pix;
      r_drv_color  <= w_load_col;
      r_drv_go     <= w_go_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

`ifdef NEOPIX_CLEAR_EN
  // Clear request latch and sweep position.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_clear_pending <= 1'b0;
      r_clr_idx       <= '0;
      r_clr_phase     <= 1'b0;
    end else begin
      if (i_clear_all) begin
        r_clear_pending <= 1'b1;
      end else if (w_clr_take) begin
        r_clear_pending <= 1'b0;
      end
      r_clr_idx   <= w_clr_idx_nxt;
      r_clr_phase <= w_clr_phase_nxt;
    end
  end
`endif

  assign o_gnt        = r_gnt;
  assign o_drv_load   = r_drv_load;
  assign o_drv_pixel  = r_drv_pixel;
  assign o_drv_color  = r_drv_color;
  assign o_drv_go     = r_drv_go;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_neopix_frame_sched.sv
// Self-checking bench for neopix_frame_sched (FRAME_CYCLES=8, 16 pixels).
// Cycle scripts apply one row of inputs per clock and compare the outputs
// of that cycle; a vector table covers pixel/colour/range cases.
// Define NEOPIX_CLEAR_EN to also exercise the clear sweep.
module tb_neopix_frame_sched;

  localparam int NPIX   = 16;
  localparam int FRAMES = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic [1:0]      req;
  logic [1:0][4:0] rpix;
  logic [1:0][2:0] rcol;
  logic [1:0]      gnt;
  logic            load;
  logic [4:0]      dpix;
  logic [2:0]      dcol;
  logic            go;
  logic            done;
`ifdef NEOPIX_CLEAR_EN
  logic            clr;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  neopix_frame_sched #(.NUM_PIXELS(NPIX), .FRAME_CYCLES(FRAMES)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req        (req),
    .i_req_pixel  (rpix),
    .i_req_color  (rcol),
    .o_gnt        (gnt),
    .i_drv_ready  (rdy),
    .o_drv_load   (load),
    .o_drv_pixel  (dpix),
    .o_drv_color  (dcol),
    .o_drv_go     (go),
    .o_frame_done (done)
`ifdef NEOPIX_CLEAR_EN
    ,
    .i_clear_all  (clr)
`endif
  );

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [4:0] p0;
    logic [2:0] c0;
    logic [4:0] p1;
    logic [2:0] c1;
    logic       rdy;
    logic [1:0] e_gnt;
    logic       e_load;
    logic [4:0] e_pix;
    logic [2:0] e_col;
    logic       e_go;
    logic       e_done;
  } row_t;

  typedef struct {
    int         who;
    logic [4:0] pix;
    logic [2:0] col;
    logic [1:0] e_gnt;
    logic       e_load;
  } vec_t;

  row_t rows[$];
  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] rq,
                     input logic [4:0] p0, input logic [2:0] c0,
                     input logic [4:0] p1, input logic [2:0] c1,
                     input logic rd, input logic [1:0] eg, input logic el,
                     input logic [4:0] ep, input logic [2:0] ec,
                     input logic ego, input logic edn);
    row_t t;
    t.rst = r;  t.req = rq; t.p0 = p0; t.c0 = c0; t.p1 = p1; t.c1 = c1;
    t.rdy = rd; t.e_gnt = eg; t.e_load = el; t.e_pix = ep; t.e_col = ec;
    t.e_go = ego; t.e_done = edn;
    rows.push_back(t);
  endtask

  task automatic add_quiet(input int n, input logic rd);
    for (int i = 0; i < n; i++) add(1'b0, 2'b00, 0, 0, 0, 0, rd, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic run_script(input string name);
    bit bad;
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].rst; req = rows[i].req; rdy = rows[i].rdy;
      rpix[0] = rows[i].p0; rcol[0] = rows[i].c0;
      rpix[1] = rows[i].p1; rcol[1] = rows[i].c1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      bad = (gnt !== rows[i].e_gnt) || (load !== rows[i].e_load) ||
            (go !== rows[i].e_go) || (done !== rows[i].e_done);
      if (rows[i].e_load && ((dpix !== rows[i].e_pix) || (dcol !== rows[i].e_col))) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL %s cycle %0d: got gnt=%b load=%b pix=%0d col=%b go=%b done=%b, want gnt=%b load=%b pix=%0d col=%b go=%b done=%b",
                 name, i + 1, gnt, load, dpix, dcol, go, done,
                 rows[i].e_gnt, rows[i].e_load, rows[i].e_pix, rows[i].e_col, rows[i].e_go, rows[i].e_done);
      end
    end
    rows.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 2'b00; rdy = 1'b1; rpix = '0; rcol = '0;
`ifdef NEOPIX_CLEAR_EN
    clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, load, dpix, dcol, go, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b load=%b pix=%0d col=%b go=%b done=%b, want all 0",
               gnt, load, dpix, dcol, go, done);
    end
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want bench to finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 2'b00; rdy = 1'b1; rpix = '0; rcol = '0;
`ifdef NEOPIX_CLEAR_EN
    clr = 1'b0;
`endif
    do_reset();

    // Single write, frame send, clean frame, ready-low hold-off, out of range.
    add(1'b0, 2'b01, 3, 3'b101, 0, 0, 1'b1, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0);    // 1 gnt0
    add(1'b0, 2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b1, 3, 3'b101, 1'b0, 1'b0);    // 2 load
    add_quiet(6, 1'b1);                                                        // 3-8 (wrap at 8)
    add(1'b0, 2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0);         // 9 go
    add_quiet(2, 1'b1);                                                        // 10-11
    add(1'b0, 2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b0, 0, 0, 1'b0, 1'b1);         // 12 done
    add_quiet(6, 1'b1);                                                        // 13-18 clean tick
    add(1'b0, 2'b01, 9, 3'b011, 0, 0, 1'b1, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0);    // 19 gnt0
    add(1'b0, 2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b1, 9, 3'b011, 1'b0, 1'b0);    // 20 load
    add_quiet(4, 1'b1);                                                        // 21-24
    add(1'b0, 2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0);         // 25 go
    for (int i = 0; i < 20; i++)                                               // 26-45 ready low
      add(1'b0, 2'b10, 0, 0, 4, 3'b110, 1'b0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0);
    add(1'b0, 2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b0, 0, 0, 1'b0, 1'b1);         // 46 done
    add_quiet(4, 1'b1);                                                        // 47-50
    add(1'b0, 2'b10, 0, 0, 20, 3'b111, 1'b1, 2'b10, 1'b0, 0, 0, 1'b0, 1'b0);   // 51 gnt1
    add_quiet(7, 1'b1);                                                        // 52-58 no load/go
    run_script("frame");

    // Vector table: grant and load for assorted requesters, pixels, colours.
    vecs.push_back('{0, 5'd5,  3'b010, 2'b01, 1'b1});
    vecs.push_back('{1, 5'd0,  3'b111, 2'b10, 1'b1});
    vecs.push_back('{1, 5'd15, 3'b001, 2'b10, 1'b1});
    vecs.push_back('{0, 5'd16, 3'b011, 2'b01, 1'b0});
    vecs.push_back('{1, 5'd31, 3'b100, 2'b10, 1'b0});
    vecs.push_back('{0, 5'd0,  3'b000, 2'b01, 1'b1});
    vecs.push_back('{1, 5'd7,  3'b101, 2'b10, 1'b1});
    for (int v = 0; v < vecs.size(); v++) begin
      int waited;
      req = 2'b00;
      req[vecs[v].who] = 1'b1;
      rpix[vecs[v].who] = vecs[v].pix;
      rcol[vecs[v].who] = vecs[v].col;
      waited = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        waited++;
      end while (gnt === 2'b00 && waited < 40);
      req = 2'b00;
      checks++;
      if (gnt !== vecs[v].e_gnt) begin
        errors++;
        $display("FAIL vec%0d grant: got %b after %0d cycles, want %b", v, gnt, waited, vecs[v].e_gnt);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ((load !== vecs[v].e_load) || (vecs[v].e_load && ((dpix !== vecs[v].pix) || (dcol !== vecs[v].col)))) begin
        errors++;
        $display("FAIL vec%0d load: got load=%b pix=%0d col=%b, want load=%b pix=%0d col=%b",
                 v, load, dpix, dcol, vecs[v].e_load, vecs[v].pix, vecs[v].col);
      end
    end

    // Contention, go priority over requests, reset in the grant cycle.
    do_reset();
    add(1'b0, 2'b11, 1, 3'b001, 2, 3'b010, 1'b1, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0);  // 1
    add(1'b0, 2'b11, 1, 3'b001, 2, 3'b010, 1'b1, 2'b00, 1'b1, 1, 3'b001, 1'b0, 1'b0);
    add(1'b0, 2'b11, 1, 3'b001, 2, 3'b010, 1'b1, 2'b10, 1'b0, 0, 0, 1'b0, 1'b0);
    add(1'b0, 2'b11, 1, 3'b001, 2, 3'b010, 1'b1, 2'b00, 1'b1, 2, 3'b010, 1'b0, 1'b0);
    add(1'b0, 2'b11, 1, 3'b001, 2, 3'b010, 1'b1, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0);  // 5
    add(1'b0, 2'b11, 1, 3'b001, 2, 3'b010, 1'b1, 2'b00, 1'b1, 1, 3'b001, 1'b0, 1'b0);
    add(1'b0, 2'b11, 1, 3'b001, 2, 3'b010, 1'b1, 2'b10, 1'b0, 0, 0, 1'b0, 1'b0);
    add(1'b0, 2'b11, 1, 3'b001, 2, 3'b010, 1'b1, 2'b00, 1'b1, 2, 3'b010, 1'b0, 1'b0);
    add(1'b0, 2'b11, 1, 3'b001, 2, 3'b010, 1'b1, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0);  // 9 go
    add_quiet(2, 1'b1);                                                           // 10-11
    add(1'b0, 2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b0, 0, 0, 1'b0, 1'b1);            // 12 done
    add(1'b0, 2'b01, 2, 3'b111, 0, 0, 1'b1, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0);       // 13 gnt0
    add(1'b1, 2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0);            // 14 reset
    add_quiet(1, 1'b1);                                                           // 15
    add(1'b0, 2'b11, 5, 3'b011, 6, 3'b100, 1'b1, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0);  // 16 ptr cleared
    add(1'b0, 2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b1, 5, 3'b011, 1'b0, 1'b0);       // 17
    add_quiet(1, 1'b1);
    run_script("contend");

`ifdef NEOPIX_CLEAR_EN
    begin
      logic [4:0] pix_log[16];
      logic [2:0] col_log[16];
      int nload, gnt_seen, low_loads, low_left;
      logic prev_rdy;
      do_reset();
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      req = 2'b01; rpix[0] = 5'd3; rcol[0] = 3'b111;
      nload = 0; gnt_seen = 0; low_loads = 0; low_left = 0; prev_rdy = 1'b1;
      for (int c = 0; c < 300 && nload < 16; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (gnt !== 2'b00) gnt_seen++;
        if (load === 1'b1) begin
          if (!prev_rdy) low_loads++;
          pix_log[nload] = dpix;
          col_log[nload] = dcol;
          nload++;
          if (dpix == 5'd6) begin
            rdy = 1'b0;
            low_left = 10;
          end
        end else if (low_left > 0) begin
          low_left--;
          if (low_left == 0) rdy = 1'b1;
        end
        prev_rdy = rdy;
      end
      req = 2'b00;
      rdy = 1'b1;
      checks++;
      if (nload != 16) begin
        errors++;
        $display("FAIL clear_count: got %0d loads, want 16", nload);
      end
      for (int i = 0; i < nload; i++) begin
        checks++;
        if ((int'(pix_log[i]) != i) || (col_log[i] !== 3'b000)) begin
          errors++;
          $display("FAIL clear_load%0d: got pix=%0d col=%b, want pix=%0d col=000", i, pix_log[i], col_log[i], i);
        end
      end
      checks++;
      if (gnt_seen != 0) begin
        errors++;
        $display("FAIL clear_stall: got %0d grants during clear, want 0", gnt_seen);
      end
      checks++;
      if (low_loads != 0) begin
        errors++;
        $display("FAIL clear_pause: got %0d loads with ready low, want 0", low_loads);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neopix_frame_sched.md
# neopix_frame_sched

Frame scheduler and two-way arbiter in front of the NeoPixel strip driver. Two requesters (game renderer, remote/score renderer) submit single-pixel colour writes. The block serialises them into the driver's load port with round-robin fairness. It also issues a frame-rate `go` strobe whenever the pixel buffer has changed, and holds off all traffic while the driver is shifting out a frame.

## Interface
Parameters:
- `NUM_PIXELS`, 16: number of pixels on the strip; legal indices are 0..NUM_PIXELS-1.
- `FRAME_CYCLES`, 833_333: clock cycles per frame tick (60 Hz at 50 MHz); must be ≥ 4.

Ports:
- `clock`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous, active-high.
- `req`  in  2: per-requester write request; level, held until granted.
- `req_pixel`  in  2×5: pixel index per requester.
- `req_color`  in  2×3: {red, blue, green} per requester.
- `gnt`  out  2: one-hot, one-cycle grant pulse.
- `drv_ready`  in  1: driver idle and able to accept load/go.
- `drv_load`  out  1: one-cycle load strobe to the driver.
- `drv_pixel`  out  5: pixel index, valid while `drv_load`=1.
- `drv_color`  out  3: colour, valid while `drv_load`=1.
- `drv_go`  out  1: one-cycle frame-send strobe.
- `frame_done`  out  1: one-cycle pulse when the driver returns ready after a `go`.
- `clear_all`  in  1: present only with `NEOPIX_CLEAR_EN` (see Configuration).

## Operation
- FSM states: IDLE, LOAD, SEND, HOLD, WAIT, plus CLEAR when the macro is defined.
- Frame timer: free-running counter, 0..FRAME_CYCLES-1. On wrap it sets `go_pending`. A wrap while `go_pending` is already set merges into the existing pending tick.
- `dirty` is set by every accepted in-range load and cleared in SEND.
- IDLE priority, highest first:
  - `go_pending` & `dirty` & `drv_ready` → SEND.
  - `go_pending` & !`dirty` → clear `go_pending`; no `go` is issued.
  - Any `req` & `drv_ready` → arbitrate. The winner's pixel and colour are registered, the winner gets a `gnt` pulse, and the FSM moves to LOAD.
- Arbitration is round-robin with a last-grant pointer. After reset the pointer favours requester 0 on a tie. The pointer updates on every grant.
- LOAD: drives `drv_load`=1 for exactly one cycle with the registered pixel and colour, then returns to IDLE. The minimum spacing between loads is 2 cycles.
- Out-of-range index (≥ NUM_PIXELS): the request is still granted, so the requester is released. In LOAD, `drv_load` stays 0 and `dirty` is unchanged.
- SEND: `drv_go`=1 for one cycle; clears `go_pending` and `dirty`. Next state is HOLD.
- HOLD: one cycle in which `drv_ready` is ignored, giving the driver time to drop ready. Next state is WAIT.
- WAIT: stays until `drv_ready`=1, then pulses `frame_done` and returns to IDLE.
- No grants are issued in SEND, HOLD or WAIT. Frame ticks arriving during these states are latched into `go_pending`.

## Timing
- Reset: all outputs are 0, FSM is in IDLE, timer is 0, and `go_pending`, `dirty` and the pointer are cleared.
- Load latency: with `req` sampled high in IDLE at edge N, `gnt` is high during cycle N+1 and `drv_load` is high during cycle N+2.
- Requesters must drop `req` in the cycle after `gnt`. If `req` is still high, it is treated as a new request.
- Go latency: a timer wrap at edge N (with `dirty` and ready) gives `drv_go` high during cycle N+2.
- `frame_done` is high in the cycle after the one where WAIT sees `drv_ready`=1.
- Reset asserted mid-frame: the FSM returns to IDLE immediately. Any registered load is discarded without a `drv_load`.

## Configuration
- `NEOPIX_CLEAR_EN` defined:
  - Adds the `clear_all` input and the CLEAR state. A `clear_all` pulse latches `clear_pending`.
  - In IDLE, `clear_pending` ranks below `go_pending` and above requests.
  - CLEAR issues colour 0 loads to pixels 0..NUM_PIXELS-1, one every 2 cycles, then sets `dirty` and returns to IDLE.
  - CLEAR pauses, without losing its index, while `drv_ready`=0. Requesters are stalled during CLEAR.
- Without the macro: there is no `clear_all` port and no CLEAR state.

## Structure
- Package `neopix_pkg` holds:
  - `color_t` (3-bit {r,b,g}) and `pixel_idx_t` (5-bit).
  - The FSM state enum.
  - The `NUM_PIXELS` default.
- Sub-module `neopix_rr_arb`: a 2-way round-robin arbiter (req, advance → one-hot grant, pointer register).

## Test plan
- Single write: req0, pixel 3, colour 3'b101 → `gnt[0]` in cycle N+1; `drv_load` with pixel 3 / 3'b101 in cycle N+2; `dirty`=1.
- Contention: both requesters held high with pixels 1 and 2 → grants alternate 0,1,0,1, and `drv_load` occurs every 2 cycles.
- Frame send: after one load and a timer wrap (FRAME_CYCLES=8 in the bench) → one `drv_go`. Driving `drv_ready` low for 20 cycles keeps all requests ungranted; when ready returns, `frame_done` pulses once.
- Clean frame: a timer wrap with no loads since the last go → no `drv_go`.
- Out of range: req1 with pixel 20 (NUM_PIXELS=16) → `gnt[1]` pulses; no `drv_load`; no `go` on the next tick.
- Clear (macro defined): a `clear_all` pulse → 16 `drv_load` pulses for pixels 0..15 with colour 0; with ready dropped at pixel 7, the sequence resumes at 7.
